// File: rtl/vending_pkg.sv
// Shared vending-machine types: coin encoding and the one-hot output FSM states.
package vending_pkg;

  typedef enum logic {
    COIN_NICKEL = 1'b0,
    COIN_DIME   = 1'b1
  } coin_t;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    GAP   = 3'b100
  } out_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Per-sensor debouncer emitting a one-cycle rise strobe on each accepted 0->1 level change.
// Optional 2-flop input synchronizer enabled by COIN_ACCEPTOR_SYNC_EN.
module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sense,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sample;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             hit;

`ifdef COIN_ACCEPTOR_SYNC_EN
  logic sync_p0;
  logic sync_p1;

  // synchronizer stages p0 -> p1
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sense;
      sync_p1 <= sync_p0;
    end
  end

  assign sample = sync_p1;
`else
  assign sample = sense;
`endif

  // The toggle happens on the edge that would bring the count to DEBOUNCE_CYCLES.
  always_comb begin
    hit  = (sample != level) && (cnt == CNT_LAST);
    rise = hit && sample;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sample == level) begin
      cnt <= '0;
    end else if (hit) begin
      level <= sample;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounced sensors feed a coin FIFO drained by a paced output FSM.
// Build option COIN_ACCEPTOR_SYNC_EN adds input synchronizers inside coin_debounce.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GAP_CYCLES      = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              nickel_sense,
  input  logic                              dime_sense,
  input  logic                              ready,
  output logic                              nickel_in,
  output logic                              dime_in,
  output logic                              coin_reject,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic nickel_rise;
  logic dime_rise;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel_db (
    .clock (clock),
    .reset (reset),
    .sense (nickel_sense),
    .rise  (nickel_rise)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime_db (
    .clock (clock),
    .reset (reset),
    .sense (dime_sense),
    .rise  (dime_rise)
  );

  coin_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  coin_t             head;
  coin_t             push_type;
  logic              fifo_full;
  logic              fifo_empty;
  logic              both_rise;
  logic              single_rise;
  logic              push;
  logic              pop;
  logic              reject_d;

  out_state_t        state_q;
  out_state_t        state_d;
  logic [GAP_W-1:0]  gap_cnt;

  // A simultaneous pop frees a slot on the same edge, so a full FIFO still takes the coin.
  always_comb begin
    fifo_full   = (fifo_count == CNT_FULL);
    fifo_empty  = (fifo_count == '0);
    head        = mem[rd_ptr];
    both_rise   = nickel_rise && dime_rise;
    single_rise = nickel_rise ^ dime_rise;
    push_type   = dime_rise ? COIN_DIME : COIN_NICKEL;
    push        = single_rise && (!fifo_full || pop);
    reject_d    = both_rise || (single_rise && fifo_full && !pop);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_type;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      gap_cnt <= '0;
    end else begin
      state_q <= state_d;
      gap_cnt <= (state_q == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  // ready only matters in IDLE; ISSUE and GAP always run to completion.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && ready) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nickel_in   <= 1'b0;
      dime_in     <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      nickel_in   <= pop && (head == COIN_NICKEL);
      dime_in     <= pop && (head == COIN_DIME);
      coin_reject <= reject_d;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor (default build): directed scenarios plus random sensor traffic.
module tb_coin_acceptor;

  localparam int D     = 4;
  localparam int DEPTH = 4;
  localparam int G     = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       nickel_sense = 1'b0;
  logic       dime_sense = 1'b0;
  logic       ready = 1'b0;
  logic       nickel_in;
  logic       dime_in;
  logic       coin_reject;
  logic [2:0] fifo_count;

  coin_acceptor #(
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH),
    .GAP_CYCLES      (G)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .nickel_sense (nickel_sense),
    .dime_sense   (dime_sense),
    .ready        (ready),
    .nickel_in    (nickel_in),
    .dime_in      (dime_in),
    .coin_reject  (coin_reject),
    .fifo_count   (fifo_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: run lengths per sensor, a queue of coins, and the earliest edge a pop may occur.
  int lvl [2];
  int run [2];
  bit mq [$];
  int edge_no   = 0;
  int next_free = 0;
  bit e_n, e_d, e_r;
  int e_cnt;

  // Observation bookkeeping for directed checks.
  int tn = 0;
  int n_seen = 0, d_seen = 0, r_seen = 0;
  int last_n_tick = 0, last_d_tick = 0;
  int pulse_ticks [$];
  bit pulse_types [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lvl[0] = 0; lvl[1] = 0;
    run[0] = 0; run[1] = 0;
    mq.delete();
    next_free = edge_no;
    e_n = 0; e_d = 0; e_r = 0; e_cnt = 0;
  endtask

  task automatic model_edge(input bit ns, input bit ds, input bit rdy);
    bit s [2];
    bit rise [2];
    bit popped;
    bit c;
    int pre;
    s[0] = ns; s[1] = ds;
    for (int i = 0; i < 2; i++) begin
      rise[i] = 0;
      if (s[i] != lvl[i]) begin
        run[i]++;
        if (run[i] == D) begin
          lvl[i]  = s[i];
          run[i]  = 0;
          rise[i] = s[i];
        end
      end else begin
        run[i] = 0;
      end
    end
    pre    = mq.size();
    popped = (pre > 0) && rdy && (edge_no >= next_free);
    e_n = 0; e_d = 0; e_r = 0;
    if (popped) begin
      c = mq.pop_front();
      e_n = !c;
      e_d = c;
      next_free = edge_no + 2 + G;
    end
    if (rise[0] && rise[1]) begin
      e_r = 1;
    end else if (rise[0] || rise[1]) begin
      if (pre < DEPTH || popped) mq.push_back(rise[1]);
      else e_r = 1;
    end
    e_cnt = mq.size();
    edge_no++;
  endtask

  task automatic tick(input bit ns, input bit ds, input bit rdy);
    nickel_sense = ns;
    dime_sense   = ds;
    ready        = rdy;
    @(posedge clock);
    if (!reset) model_reset();
    else model_edge(ns, ds, rdy);
    @(negedge clock);
    tn++;
    check("nickel_in", nickel_in, e_n);
    check("dime_in", dime_in, e_d);
    check("coin_reject", coin_reject, e_r);
    check("fifo_count", fifo_count, e_cnt);
    check("pulse_exclusive", nickel_in & dime_in, 0);
    if (nickel_in) begin n_seen++; last_n_tick = tn; pulse_ticks.push_back(tn); pulse_types.push_back(1'b0); end
    if (dime_in)   begin d_seen++; last_d_tick = tn; pulse_ticks.push_back(tn); pulse_types.push_back(1'b1); end
    if (coin_reject) r_seen++;
  endtask

  task automatic insert_coin(input bit dime, input bit rdy);
    for (int i = 0; i < 5; i++) tick(!dime, dime, rdy);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, rdy);
  endtask

  initial begin
    int first, n0, d0, r0;
    int bound;
    bit rs_n, rs_d, rs_r;

    model_reset();
    repeat (3) tick(0, 0, 0);
    check("reset_count", fifo_count, 0);
    check("reset_outputs", {nickel_in, dime_in, coin_reject}, 0);
    reset = 1'b1;
    repeat (2) tick(0, 0, 1);

    // single nickel: latency and count trace
    n0 = n_seen;
    first = tn + 1;
    for (int i = 1; i <= 6; i++) begin
      tick(1, 0, 1);
      if (i == 4) check("nickel_count_up", fifo_count, 1);
    end
    repeat (8) tick(0, 0, 1);
    check("nickel_once", n_seen - n0, 1);
    check("nickel_latency", last_n_tick - first, D);

    // dime glitch then steady high; short nickel glitch ignored
    d0 = d_seen; n0 = n_seen;
    tick(0, 0, 1); tick(0, 1, 1); tick(0, 0, 1);
    repeat (6) tick(0, 1, 1);
    repeat (8) tick(0, 0, 1);
    repeat (3) tick(1, 0, 1);
    repeat (8) tick(0, 0, 1);
    check("dime_once", d_seen - d0, 1);
    check("glitch_ignored", n_seen - n0, 0);

    // both sensors together
    n0 = n_seen; d0 = d_seen; r0 = r_seen;
    repeat (6) tick(1, 1, 1);
    repeat (8) tick(0, 0, 1);
    check("both_reject", r_seen - r0, 1);
    check("both_no_credit", (n_seen - n0) + (d_seen - d0), 0);
    check("both_count", fifo_count, 0);

    // overflow with ready low, then drain
    r0 = r_seen; n0 = n_seen;
    for (int i = 0; i < 4; i++) insert_coin(0, 0);
    check("fifo_full", fifo_count, DEPTH);
    insert_coin(0, 0);
    check("overflow_reject", r_seen - r0, 1);
    check("overflow_count", fifo_count, DEPTH);
    pulse_ticks.delete();
    repeat (14) tick(0, 0, 1);
    check("drain_pulses", n_seen - n0, 4);
    for (int i = 1; i < pulse_ticks.size(); i++)
      check("drain_spacing", pulse_ticks[i] - pulse_ticks[i-1], 2 + G);

    // ordering and ready held off between coins
    insert_coin(0, 0); insert_coin(1, 0); insert_coin(0, 0);
    check("order_buffered", fifo_count, 3);
    pulse_types.delete();
    n0 = n_seen; d0 = d_seen;
    bound = 0;
    while (n_seen == n0 && bound < 10) begin tick(0, 0, 1); bound++; end
    check("order_first_seen", n_seen - n0, 1);
    repeat (6) tick(0, 0, 0);
    check("order_held", d_seen - d0, 0);
    repeat (10) tick(0, 0, 1);
    check("order_len", pulse_types.size(), 3);
    if (pulse_types.size() == 3) begin
      check("order_0", pulse_types[0], 0);
      check("order_1", pulse_types[1], 1);
      check("order_2", pulse_types[2], 0);
    end

    // reset mid-pulse with three coins still buffered
    for (int i = 0; i < 4; i++) insert_coin(1, 0);
    d0 = d_seen;
    bound = 0;
    while (d_seen == d0 && bound < 10) begin tick(0, 0, 1); bound++; end
    check("pre_reset_dime", dime_in, 1);
    check("pre_reset_count", fifo_count, 3);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {nickel_in, dime_in, coin_reject}, 0);
    check("async_reset_count", fifo_count, 0);
    model_reset();
    tick(0, 0, 1);
    tick(1, 0, 1);
    reset = 1'b1;
    n0 = n_seen; d0 = d_seen;
    repeat (6) tick(1, 0, 1);
    repeat (10) tick(0, 0, 1);
    check("post_reset_nickel", n_seen - n0, 1);
    check("post_reset_no_stale", d_seen - d0, 0);
    check("post_reset_count", fifo_count, 0);

    // random traffic against the model
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      len  = $urandom_range(1, 8);
      rs_n = ($urandom_range(0, 2) == 0);
      rs_d = ($urandom_range(0, 3) == 0);
      rs_r = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < len; i++) tick(rs_n, rs_d, rs_r);
    end
    repeat (30) tick(0, 0, 1);
    check("final_drained", fifo_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
